s2mm_packet_mux: RTL and testbench

- Return-path counterpart of the mm2s tdest router.
- Drains NUM_FIFOS accelerator output FIFOs (standard, non-FWFT) into a single AXI Stream feeding the slave s2mm port of the MCDMA.
- Packetises each FIFO's data: tdest = FIFO index, tlast on the final word of a configurable-length packet.
- Arbitrates round-robin between FIFOs at packet granularity; never interleaves packets.

---
 rtl/s2mm_packet_mux_pkg.sv | 29 ++
 rtl/s2mm_out_buffer.sv | 94 +++++++++
 rtl/s2mm_packet_mux.sv | 192 +++++++++++++++++++
 tb/tb_s2mm_packet_mux.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2mm_packet_mux_pkg.sv
// s2mm_packet_mux_pkg
// Shared definitions for the s2mm packet mux and its output buffer:
//   - FSM state encoding
//   - round-robin index helpers (wrap modulo the channel count)
//   - flattened-vector slice helper, same layout as the mm2s side
package s2mm_packet_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Wrap a value in [0, 2*num) back into [0, num).
  function automatic int rr_wrap(input int value, input int num);
    return (value >= num) ? (value - num) : value;
  endfunction

  // Channel that follows idx in round-robin order.
  function automatic int rr_next(input int idx, input int num);
    return rr_wrap(idx + 1, num);
  endfunction

  // LSB of channel idx inside a flattened {ch[N-1], ..., ch[0]} vector.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/s2mm_out_buffer.sv
// s2mm_out_buffer
// Two-entry registered AXI-Stream output stage. Entry 0 is the head and
// drives the stream outputs directly from flops, so tdata/tdest/tlast stay
// put while tvalid is high and tready is low.
// Ports:
//   clk, rst            clock, async active-high reset
//   push, push_data,
//   push_dest, push_last  write one entry (caller guarantees room)
//   ready               downstream tready; pop = valid & ready
//   occ                 current occupancy 0..2
//   out_valid/data/dest/last  head entry
module s2mm_out_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [DEST_WIDTH-1:0] push_dest,
  input  logic                  push_last,
  input  logic                  ready,
  output logic [1:0]            occ,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_last
);

  logic [DATA_WIDTH-1:0] data1_r;
  logic [DEST_WIDTH-1:0] dest1_r;
  logic                  last1_r;
  logic [1:0]            occ_r;
  logic                  pop_s;

  assign pop_s = out_valid & ready;
  assign occ   = occ_r;

  // Shift-register style storage: head is always entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
      out_last  <= 1'b0;
      data1_r   <= '0;
      dest1_r   <= '0;
      last1_r   <= 1'b0;
    end else begin
      case ({push, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            out_data  <= push_data;
            out_dest  <= push_dest;
            out_last  <= push_last;
            out_valid <= 1'b1;
          end else begin
            data1_r <= push_data;
            dest1_r <= push_dest;
            last1_r <= push_last;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          out_data  <= data1_r;
          out_dest  <= dest1_r;
          out_last  <= last1_r;
          out_valid <= (occ_r == 2'd2);
          occ_r     <= occ_r - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new word lands behind whatever remains.
          if (occ_r == 2'd1) begin
            out_data <= push_data;
            out_dest <= push_dest;
            out_last <= push_last;
          end else begin
            out_data <= data1_r;
            out_dest <= dest1_r;
            out_last <= last1_r;
            data1_r  <= push_data;
            dest1_r  <= push_dest;
            last1_r  <= push_last;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/s2mm_packet_mux.sv
// s2mm_packet_mux
// Drains NUM_FIFOS standard (non-FWFT) FIFOs into one AXI-Stream toward the
// MCDMA s2mm port. Each grant moves one packet of pkt_len[ch] words (0 means
// 1) with tdest = channel and tlast on the final word. Channels are served
// round-robin at packet granularity; packets never interleave.
// Ports:
//   clk, rst         clock, async active-high reset
//   fifo_rden        per-FIFO read enable (at most one bit high)
//   fifo_empty       per-FIFO empty flag
//   fifo_data        flattened read data, valid the cycle after rden
//   pkt_len          flattened per-channel packet length
//   DST_AXIS_*       output stream
//   busy             grant through acceptance of the tlast beat
module s2mm_packet_mux
  import s2mm_packet_mux_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int NUM_FIFOS       = 2,
  parameter int PKT_LEN_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic [NUM_FIFOS-1:0]                 fifo_rden,
  input  logic [NUM_FIFOS-1:0]                 fifo_empty,
  input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_FIFOS*PKT_LEN_WIDTH-1:0]   pkt_len,
  output logic [AXIS_DATA_WIDTH-1:0]           DST_AXIS_tdata,
  output logic [AXIS_DEST_WIDTH-1:0]           DST_AXIS_tdest,
  output logic                                 DST_AXIS_tvalid,
  input  logic                                 DST_AXIS_tready,
  output logic                                 DST_AXIS_tlast,
  output logic                                 busy
);

  localparam int IDX_W = AXIS_DEST_WIDTH;

  state_t                     state_r;
  logic [IDX_W-1:0]           rr_ptr_r;
  logic [IDX_W-1:0]           grant_r;
  logic [PKT_LEN_WIDTH-1:0]   len_r;
  logic [PKT_LEN_WIDTH-1:0]   issued_r;
  logic [PKT_LEN_WIDTH-1:0]   pushed_r;
  logic                       inflight_r;
  logic                       busy_r;

  logic                       scan_hit_s;
  logic [IDX_W-1:0]           scan_idx_s;
  logic [PKT_LEN_WIDTH-1:0]   scan_len_s;
  logic [PKT_LEN_WIDTH-1:0]   raw_len_s;
  logic [NUM_FIFOS-1:0]       rden_s;
  logic [AXIS_DATA_WIDTH-1:0] push_data_s;
  logic                       push_last_s;
  logic [1:0]                 occ_s;
  logic                       pop_s;
  logic [2:0]                 room_s;

  assign fifo_rden = rden_s;
  assign busy      = busy_r;
  assign pop_s     = DST_AXIS_tvalid & DST_AXIS_tready;

  // Round-robin scan: first non-empty channel at or after rr_ptr.
  always_comb begin
    scan_hit_s = 1'b0;
    scan_idx_s = '0;
    raw_len_s  = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      for (int j = 0; j < NUM_FIFOS; j++) begin
        if (!scan_hit_s && !fifo_empty[j] &&
            (j == rr_wrap(int'(rr_ptr_r) + i, NUM_FIFOS))) begin
          scan_hit_s = 1'b1;
          scan_idx_s = IDX_W'(j);
          raw_len_s  = pkt_len[slice_lsb(j, PKT_LEN_WIDTH) +: PKT_LEN_WIDTH];
        end else begin
          scan_hit_s = scan_hit_s;
        end
      end
    end
    // A zero length would never produce tlast, so it is promoted to one word.
    scan_len_s = (raw_len_s == '0) ? PKT_LEN_WIDTH'(1) : raw_len_s;
  end

  // Read issue: granted channel only, bounded so the 2-entry buffer never overflows.
  always_comb begin
    room_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if ((state_r == ST_XFER) && (grant_r == IDX_W'(i)) && !fifo_empty[i] &&
          (issued_r < len_r) && (room_s < 3'd2)) begin
        rden_s[i] = 1'b1;
      end else begin
        rden_s[i] = 1'b0;
      end
    end
  end

  // Select the granted channel's read data, zero-extended to the stream width.
  always_comb begin
    push_data_s = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      push_data_s = push_data_s |
                    ((grant_r == IDX_W'(i)) ?
                     AXIS_DATA_WIDTH'(fifo_data[slice_lsb(i, FIFO_DATA_WIDTH) +: FIFO_DATA_WIDTH]) :
                     '0);
    end
    push_last_s = (pushed_r == (len_r - PKT_LEN_WIDTH'(1)));
  end

  // Packet FSM plus issued/pushed word counters and the read-in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      grant_r    <= '0;
      len_r      <= '0;
      issued_r   <= '0;
      pushed_r   <= '0;
      inflight_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      inflight_r <= |rden_s;
      case (state_r)
        ST_IDLE: begin
          if (scan_hit_s) begin
            grant_r  <= scan_idx_s;
            len_r    <= scan_len_s;
            issued_r <= '0;
            pushed_r <= '0;
            busy_r   <= 1'b1;
            state_r  <= ST_XFER;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (|rden_s) begin
            issued_r <= issued_r + PKT_LEN_WIDTH'(1);
          end else begin
            issued_r <= issued_r;
          end
          if (inflight_r) begin
            pushed_r <= pushed_r + PKT_LEN_WIDTH'(1);
          end else begin
            pushed_r <= pushed_r;
          end
          if (issued_r == len_r) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_DRAIN: begin
          // The final read may still be in flight when we arrive here.
          if (inflight_r) begin
            pushed_r <= pushed_r + PKT_LEN_WIDTH'(1);
          end else begin
            pushed_r <= pushed_r;
          end
          if (pop_s && DST_AXIS_tlast) begin
            rr_ptr_r <= IDX_W'(rr_next(int'(grant_r), NUM_FIFOS));
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  s2mm_out_buffer #(
    .DATA_WIDTH(AXIS_DATA_WIDTH),
    .DEST_WIDTH(AXIS_DEST_WIDTH)
  ) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (push_data_s),
    .push_dest (grant_r),
    .push_last (push_last_s),
    .ready     (DST_AXIS_tready),
    .occ       (occ_s),
    .out_valid (DST_AXIS_tvalid),
    .out_data  (DST_AXIS_tdata),
    .out_dest  (DST_AXIS_tdest),
    .out_last  (DST_AXIS_tlast)
  );

endmodule

// File: tb/tb_s2mm_packet_mux.sv
// tb_s2mm_packet_mux
// Self-checking bench: FIFO models feed the mux, expected beats are queued
// as stimulus is applied and compared as the stream accepts them.
module tb_s2mm_packet_mux;

  localparam int DW = 32;
  localparam int FW = 32;
  localparam int TW = 4;
  localparam int NF = 2;
  localparam int LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NF-1:0]    fifo_rden;
  logic [NF-1:0]    fifo_empty;
  logic [NF*FW-1:0] fifo_data;
  logic [NF*LW-1:0] pkt_len;
  logic [DW-1:0]    tdata;
  logic [TW-1:0]    tdest;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic             busy;

  s2mm_packet_mux #(
    .AXIS_DATA_WIDTH(DW), .FIFO_DATA_WIDTH(FW), .AXIS_DEST_WIDTH(TW),
    .NUM_FIFOS(NF), .PKT_LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .fifo_rden(fifo_rden), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .pkt_len(pkt_len),
    .DST_AXIS_tdata(tdata), .DST_AXIS_tdest(tdest), .DST_AXIS_tvalid(tvalid),
    .DST_AXIS_tready(tready), .DST_AXIS_tlast(tlast), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] dest;
    logic          last;
  } beat_t;

  typedef struct {
    logic          ch;
    logic [LW-1:0] len;
    int            nwords;
    logic [DW-1:0] base;
    int            exp_beats;
  } vec_t;

  beat_t exp_q[$];

  // Standard FIFO models: data appears the cycle after rden.
  logic [FW-1:0] mem [NF][256];
  logic [7:0]    wr_ptr [NF];
  logic [7:0]    rd_ptr [NF] = '{8'd0, 8'd0};
  logic [FW-1:0] fifo_dq [NF] = '{32'd0, 32'd0};

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (fifo_rden[i] && (rd_ptr[i] != wr_ptr[i])) begin
        fifo_dq[i] <= mem[i][rd_ptr[i]];
        rd_ptr[i]  <= rd_ptr[i] + 8'd1;
      end
    end
  end

  assign fifo_data     = {fifo_dq[1], fifo_dq[0]};
  assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [NF-1:0] allowed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic ch, input logic [FW-1:0] d);
    if (ch) begin
      mem[1][wr_ptr[1]] = d;
      wr_ptr[1] = wr_ptr[1] + 8'd1;
    end else begin
      mem[0][wr_ptr[0]] = d;
      wr_ptr[0] = wr_ptr[0] + 8'd1;
    end
  endtask

  task automatic set_len(input logic ch, input logic [LW-1:0] v);
    if (ch) pkt_len[2*LW-1:LW] = v;
    else    pkt_len[LW-1:0]    = v;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic l);
    beat_t b;
    b.data = d; b.dest = t; b.last = l;
    exp_q.push_back(b);
  endtask

  // Stream monitor: scoreboard compare, AXIS stability, rden legality, busy.
  task automatic monitor();
    beat_t         e;
    logic          stall_p = 1'b0;
    logic          busy_chk = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [TW-1:0] pt = '0;
    logic          pl = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stall_p  = 1'b0;
        busy_chk = 1'b0;
      end else begin
        if (busy_chk) begin
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_tlast got %0b want 0", busy);
          end
          busy_chk = 1'b0;
        end
        if (stall_p) begin
          checks++;
          if (tvalid !== 1'b1 || tdata !== pd || tdest !== pt || tlast !== pl) begin
            errors++;
            $display("FAIL axis_stable got v=%0b d=%h t=%0d l=%0b want v=1 d=%h t=%0d l=%0b",
                     tvalid, tdata, tdest, tlast, pd, pt, pl);
          end
        end
        if (fifo_rden != '0) begin
          checks++;
          if (((fifo_rden & ~allowed) != '0) || ((fifo_rden & fifo_empty) != '0) ||
              ($countones(fifo_rden) > 1)) begin
            errors++;
            $display("FAIL rden_legal got rden=%b empty=%b want subset of %b, non-empty, one-hot",
                     fifo_rden, fifo_empty, allowed);
          end
        end
        if (tvalid && tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got d=%h t=%0d l=%0b want no beat", tdata, tdest, tlast);
          end else begin
            e = exp_q.pop_front();
            if (tdata !== e.data || tdest !== e.dest || tlast !== e.last || busy !== 1'b1) begin
              errors++;
              $display("FAIL beat got d=%h t=%0d l=%0b busy=%0b want d=%h t=%0d l=%0b busy=1",
                       tdata, tdest, tlast, busy, e.data, e.dest, e.last);
            end
          end
          if (beat_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          beat_cnt++;
          if (tlast) busy_chk = 1'b1;
        end
        stall_p = tvalid && !tready;
        pd = tdata;
        pt = tdest;
        pl = tlast;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    exp_q.delete();
    beat_cnt = 0;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || fifo_rden !== '0 ||
        tdata !== '0 || tdest !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b l=%0b busy=%0b rden=%b d=%h t=%0d want all 0",
               tvalid, tlast, busy, fifo_rden, tdata, tdest);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d beats pending want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  vec_t vecs[5];

  initial begin
    rst     = 1'b1;
    tready  = 1'b1;
    pkt_len = '0;
    allowed = 2'b00;
    wr_ptr  = '{8'd0, 8'd0};

    vecs[0] = '{1'b0, 16'd4, 4, 32'h0000_00A0, 4};
    vecs[1] = '{1'b1, 16'd3, 3, 32'h0000_00B0, 3};
    vecs[2] = '{1'b0, 16'd0, 1, 32'h0000_00C0, 1};
    vecs[3] = '{1'b1, 16'd1, 1, 32'h0000_00D0, 1};
    vecs[4] = '{1'b0, 16'd7, 7, 32'h0000_00E0, 7};

    fork
      monitor();
    join_none

    // Single-packet vectors, tready held high.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      allowed = vecs[v].ch ? 2'b10 : 2'b01;
      set_len(vecs[v].ch, vecs[v].len);
      for (int k = 0; k < vecs[v].exp_beats; k++)
        push_exp(vecs[v].base + DW'(k), {{(TW-1){1'b0}}, vecs[v].ch}, k == vecs[v].exp_beats - 1);
      for (int k = 0; k < vecs[v].nwords; k++)
        push_word(vecs[v].ch, vecs[v].base + FW'(k));
      wait_drain(100);
      checks++;
      if (beat_cnt != vecs[v].exp_beats || (last_cyc - first_cyc) != vecs[v].exp_beats - 1) begin
        errors++;
        $display("FAIL vec%0d_throughput got %0d beats over %0d cycles want %0d beats over %0d",
                 v, beat_cnt, last_cyc - first_cyc + 1, vecs[v].exp_beats, vecs[v].exp_beats);
      end
    end

    // Round-robin: 8 words each, 2-word packets, alternate 0,1,0,1...
    do_reset();
    allowed = 2'b11;
    set_len(1'b0, 16'd2);
    set_len(1'b1, 16'd2);
    for (int p = 0; p < 8; p++)
      for (int k = 0; k < 2; k++)
        push_exp(((p % 2) == 1 ? 32'h20 : 32'h10) + DW'((p / 2) * 2 + k), TW'(p % 2), k == 1);
    for (int k = 0; k < 8; k++) begin
      push_word(1'b0, 32'h10 + FW'(k));
      push_word(1'b1, 32'h20 + FW'(k));
    end
    wait_drain(200);

    // Backpressure: tready pattern 1,0,0,1.
    do_reset();
    allowed = 2'b01;
    set_len(1'b0, 16'd6);
    for (int k = 0; k < 6; k++) push_exp(32'h60 + DW'(k), 4'd0, k == 5);
    for (int k = 0; k < 6; k++) push_word(1'b0, 32'h60 + FW'(k));
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      tready = ((n % 4) == 0) || ((n % 4) == 3);
      tick();
    end
    tready = 1'b1;
    wait_drain(50);

    // Mid-packet starvation on ch1 while ch0 waits.
    do_reset();
    allowed = 2'b11;
    set_len(1'b0, 16'd5);
    set_len(1'b1, 16'd5);
    for (int k = 0; k < 5; k++) push_exp(32'h30 + DW'(k), 4'd1, k == 4);
    for (int k = 0; k < 5; k++) push_exp(32'h40 + DW'(k), 4'd0, k == 4);
    push_word(1'b1, 32'h30);
    push_word(1'b1, 32'h31);
    repeat (3) tick();
    for (int k = 0; k < 5; k++) push_word(1'b0, 32'h40 + FW'(k));
    repeat (10) tick();
    for (int k = 2; k < 5; k++) push_word(1'b1, 32'h30 + FW'(k));
    wait_drain(100);

    // Reset after 3 of 8 beats; remaining ch0 words then ch1 afterwards.
    do_reset();
    allowed = 2'b01;
    set_len(1'b0, 16'd8);
    for (int k = 0; k < 3; k++) push_exp(32'h50 + DW'(k), 4'd0, 1'b0);
    for (int k = 0; k < 8; k++) push_word(1'b0, 32'h50 + FW'(k));
    begin
      int n = 0;
      logic [7:0] rem;
      logic [7:0] idx;
      while (beat_cnt < 3 && n < 50) begin
        tick();
        n++;
      end
      checks++;
      if (beat_cnt < 3) begin
        errors++;
        $display("FAIL pre_reset_beats got %0d want 3", beat_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || fifo_rden !== '0 ||
          tdata !== '0 || tdest !== '0) begin
        errors++;
        $display("FAIL midpkt_reset got v=%0b l=%0b busy=%0b rden=%b d=%h t=%0d want all 0",
                 tvalid, tlast, busy, fifo_rden, tdata, tdest);
      end
      exp_q.delete();
      beat_cnt = 0;
      rem = wr_ptr[0] - rd_ptr[0];
      checks++;
      if (rem == 8'd0) begin
        errors++;
        $display("FAIL remaining_words got 0 want nonzero");
      end
      allowed = 2'b11;
      set_len(1'b0, {8'd0, rem});
      set_len(1'b1, 16'd2);
      for (int k = 0; k < int'(rem); k++) begin
        idx = rd_ptr[0] + 8'(k);
        push_exp(mem[0][idx], 4'd0, k == int'(rem) - 1);
      end
      push_exp(32'h70, 4'd1, 1'b0);
      push_exp(32'h71, 4'd1, 1'b1);
      push_word(1'b1, 32'h70);
      push_word(1'b1, 32'h71);
      tick();
      rst = 1'b0;
      wait_drain(100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
